// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and imem (slave).
// rdata is valid in any cycle where ready is high.
interface fetch_stage_if;
    logic [31:0] addr;
    logic        req;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output addr,
        output req,
        input  ready,
        input  rdata
    );

    modport slave (
        input  addr,
        input  req,
        output ready,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC and the IF/ID register, applies decode stalls and
// redirects with delay-slot semantics, and remembers a redirect while imem is busy.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                stall_i,
    input  logic                jump_branch_i,
    input  logic                jump_target_i,
    input  logic                jump_reg_i,
    input  logic [31:0]         jr_pc_i,
    input  logic [31:0]         branch_offset_i,
    output logic [31:0]         pc_id_o,
    output logic [31:0]         instr_id_o,
    output logic                valid_id_o,
    output logic                redirect_pending_o
);

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] pc_if_q;
    logic [31:0] pc_id_q;
    logic [31:0] instr_id_q;
    logic        valid_id_q;
    logic [31:0] redirect_pc_q;

    logic [31:0] pc_id_p4;
    logic [31:0] target_d;
    logic [31:0] pc_if_d;
    logic        redir;
    logic        fire;

    assign imem.req  = ~rst;
    assign imem.addr = pc_if_q;

    assign pc_id_o            = pc_id_q;
    assign instr_id_o         = instr_id_q;
    assign valid_id_o         = valid_id_q;
    assign redirect_pending_o = (state_q == PENDING);

    always_comb begin
        pc_id_p4 = pc_id_q + 32'd4;
        // Register jump wins over J/JAL, which wins over a conditional branch.
        if (jump_reg_i)
            target_d = jr_pc_i & ~32'h3;
        else if (jump_target_i)
            target_d = {pc_id_p4[31:28], instr_id_q[25:0], 2'b00};
        else
            target_d = pc_id_p4 + branch_offset_i;

        // Decode operands are not trustworthy during a stall, so no redirect then.
        redir = valid_id_q & ~stall_i & (jump_target_i | jump_branch_i);
        fire  = imem.req & imem.ready & ~stall_i;

        if (redir)
            pc_if_d = target_d;
        else if (state_q == PENDING)
            pc_if_d = redirect_pc_q;
        else
            pc_if_d = pc_if_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_if_q       <= RESET_PC;
            pc_id_q       <= RESET_PC;
            instr_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
        end else if (!stall_i) begin
            pc_id_q <= pc_if_q;
            if (fire) begin
                // The word completing now is the delay slot of any redirect in flight.
                pc_if_q    <= pc_if_d;
                instr_id_q <= imem.rdata;
                valid_id_q <= 1'b1;
                state_q    <= RUN;
            end else begin
                instr_id_q <= NOP_INSTR;
                valid_id_q <= 1'b0;
                if (redir) begin
                    state_q       <= PENDING;
                    redirect_pc_q <= target_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives one cycle, queues the expected
// IF/ID contents and compares them after the clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } id_t;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_branch_i;
    logic        jump_target_i;
    logic        jump_reg_i;
    logic [31:0] jr_pc_i;
    logic [31:0] branch_offset_i;
    logic [31:0] pc_id_o;
    logic [31:0] instr_id_o;
    logic        valid_id_o;
    logic        redirect_pending_o;

    int  checks;
    int  failures;
    id_t sb_q[$];
    id_t held;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem               (imem_bus.master),
        .stall_i            (stall_i),
        .jump_branch_i      (jump_branch_i),
        .jump_target_i      (jump_target_i),
        .jump_reg_i         (jump_reg_i),
        .jr_pc_i            (jr_pc_i),
        .branch_offset_i    (branch_offset_i),
        .pc_id_o            (pc_id_o),
        .instr_id_o         (instr_id_o),
        .valid_id_o         (valid_id_o),
        .redirect_pending_o (redirect_pending_o)
    );

    // Instruction memory contents; 0x8000_0010 holds "j 0x40".
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0010)
            return 32'h0800_0040;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    assign imem_bus.rdata = mem_word(imem_bus.addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic stl, input logic jb, input logic jt,
                        input logic jr, input logic [31:0] jrpc, input logic [31:0] off,
                        input logic [31:0] exp_addr, input logic exp_pend);
        id_t e;
        id_t got;
        check("imem_addr", imem_bus.addr, exp_addr);
        imem_bus.ready  = rdy;
        stall_i         = stl;
        jump_branch_i   = jb;
        jump_target_i   = jt;
        jump_reg_i      = jr;
        jr_pc_i         = jrpc;
        branch_offset_i = off;
        if (stl) begin
            e = held;
        end else if (rdy) begin
            e.pc    = exp_addr;
            e.instr = mem_word(exp_addr);
            e.valid = 1'b1;
        end else begin
            e.pc    = exp_addr;
            e.instr = NOP;
            e.valid = 1'b0;
        end
        sb_q.push_back(e);
        held = e;
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        check("pc_id", pc_id_o, got.pc);
        check("instr_id", instr_id_o, got.instr);
        check("valid_id", 32'(valid_id_o), 32'(got.valid));
        check("redirect_pending", 32'(redirect_pending_o), 32'(exp_pend));
        $display("step addr=%h rdy=%0d stall=%0d -> pc_id=%h instr=%h valid=%0d pend=%0d",
                 exp_addr, rdy, stl, pc_id_o, instr_id_o, valid_id_o, redirect_pending_o);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        stall_i         = 1'b0;
        jump_branch_i   = 1'b0;
        jump_target_i   = 1'b0;
        jump_reg_i      = 1'b0;
        jr_pc_i         = 32'h0;
        branch_offset_i = 32'h0;
        imem_bus.ready  = 1'b1;
        held.pc         = 32'h0;
        held.instr      = NOP;
        held.valid      = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_bus.req), 32'h0);
        check("rst_addr", imem_bus.addr, 32'h0);
        check("rst_pc_id", pc_id_o, 32'h0);
        check("rst_instr", instr_id_o, NOP);
        check("rst_valid", 32'(valid_id_o), 32'h0);
        check("rst_pend", 32'(redirect_pending_o), 32'h0);
        rst = 1'b0;
        #1;
        check("req_after_rst", 32'(imem_bus.req), 32'h1);

        // T1: sequential fetch
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0004, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0008, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_000C, 0);
        // T2: BEQ at 0x10, offset 0x20; 0x14 is the delay slot
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0010, 0);
        step(1, 0, 1, 0, 0, 32'h0, 32'h20, 32'h0000_0014, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0034, 0);
        // T3: JR with unaligned rs; jump_reg outranks the branch also asserted
        step(1, 0, 1, 1, 1, 32'h1003, 32'h400, 32'h0000_0038, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_1000, 0);
        // T4: JR to 0x8000_0010, then J instr_index 0x40 (outranks branch)
        step(1, 0, 0, 1, 1, 32'h8000_0010, 32'h0, 32'h0000_1004, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_0010, 0);
        step(1, 0, 1, 1, 0, 32'h0, 32'h40, 32'h8000_0014, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_0100, 0);
        // T5: stall with a taken branch presented; nothing moves, no redirect
        step(1, 1, 1, 0, 0, 32'h0, 32'h40, 32'h8000_0104, 0);
        step(1, 1, 1, 0, 0, 32'h0, 32'h40, 32'h8000_0104, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_0104, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_0108, 0);
        // T6: branch at 0x8000_0108 to 0x200 (offset wraps) while imem is busy
        step(0, 0, 1, 0, 0, 32'h0, 32'h8000_00F4, 32'h8000_010C, 1);
        step(0, 0, 1, 0, 0, 32'h0, 32'h8000_00F4, 32'h8000_010C, 1);
        step(0, 0, 1, 0, 0, 32'h0, 32'h8000_00F4, 32'h8000_010C, 1);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8000_010C, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0200, 0);
        // T7: reset in the middle of a pending wait
        step(0, 0, 1, 0, 0, 32'h0, 32'h100, 32'h0000_0204, 1);
        rst = 1'b1;
        #1;
        check("async_addr", imem_bus.addr, 32'h0);
        check("async_pend", 32'(redirect_pending_o), 32'h0);
        check("async_req", 32'(imem_bus.req), 32'h0);
        check("async_valid", 32'(valid_id_o), 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        held.pc    = 32'h0;
        held.instr = NOP;
        held.valid = 1'b0;
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0004, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
